// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational execute-stage ALU between two requesters
// (0 = integer pipe, 1 = branch/address unit). Round-robin arbitration
// feeds a registered ALU input stage; the ALU result is captured one
// cycle later into a 2-entry in-order response FIFO per requester.
//
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   REQx_VALID/READY            issue handshake per requester
//   REQx_IN1/IN2/OP             operands and ALU op code
//   ALU_IN1/IN2/INSTRUCTION     registered operands/op to the ALU
//   ALU_OUT, BRANCH_TAKEN       combinational ALU result
//   RSPx_VALID/READY            response handshake per requester
//   RSPx_DATA/BRANCH            head-entry result and branch flag
//   BUSY                        any operation outstanding
module alu_share_arbiter #(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         OP_WIDTH   = 5,
  parameter logic [OP_WIDTH-1:0] ALU_NOP    = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [DATA_WIDTH-1:0] REQ0_IN1,
  input  logic [DATA_WIDTH-1:0] REQ0_IN2,
  input  logic [OP_WIDTH-1:0]   REQ0_OP,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic [DATA_WIDTH-1:0] REQ1_IN1,
  input  logic [DATA_WIDTH-1:0] REQ1_IN2,
  input  logic [OP_WIDTH-1:0]   REQ1_OP,
  output logic [DATA_WIDTH-1:0] ALU_IN1,
  output logic [DATA_WIDTH-1:0] ALU_IN2,
  output logic [OP_WIDTH-1:0]   ALU_INSTRUCTION,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  BRANCH_TAKEN,
  output logic                  RSP0_VALID,
  input  logic                  RSP0_READY,
  output logic [DATA_WIDTH-1:0] RSP0_DATA,
  output logic                  RSP0_BRANCH,
  output logic                  RSP1_VALID,
  input  logic                  RSP1_READY,
  output logic [DATA_WIDTH-1:0] RSP1_DATA,
  output logic                  RSP1_BRANCH,
  output logic                  BUSY
);

  // Outstanding ops per requester: accepted but not yet popped (0..2)
  logic [1:0] cnt_q [2];
  logic       last_grant_q;

  logic                  stage_valid_q;
  logic                  stage_tag_q;
  logic [DATA_WIDTH-1:0] alu_in1_q;
  logic [DATA_WIDTH-1:0] alu_in2_q;
  logic [OP_WIDTH-1:0]   alu_op_q;

  // Response FIFOs: entry = {data, branch}; bit i of the pointers belongs to requester i
  logic [DATA_WIDTH:0] fifo_mem_q [2][2];
  logic [1:0]          fifo_rd_q;
  logic [1:0]          fifo_wr_q;
  logic [1:0]          fifo_cnt_q [2];

  logic [1:0] req_valid;
  logic [1:0] rsp_ready;
  logic [1:0] rsp_valid;
  logic [1:0] pop;
  logic [1:0] push;
  logic [1:0] eligible;
  logic [1:0] ready;
  logic [1:0] grant;

  logic [DATA_WIDTH:0]   head0;
  logic [DATA_WIDTH:0]   head1;
  logic [DATA_WIDTH-1:0] win_in1;
  logic [DATA_WIDTH-1:0] win_in2;
  logic [OP_WIDTH-1:0]   win_op;

  assign req_valid = {REQ1_VALID, REQ0_VALID};
  assign rsp_ready = {RSP1_READY, RSP0_READY};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i] = !RESET && (fifo_cnt_q[i] != 2'd0);
    end
    pop = rsp_valid & rsp_ready;
    // (cnt - pop) < 2 with cnt <= 2: a full requester frees a slot when it pops
    for (int i = 0; i < 2; i++) begin
      eligible[i] = (cnt_q[i] != 2'd2) || pop[i];
    end
    // Each READY yields only to a contending peer that holds priority
    ready[0] = !RESET && eligible[0] && !(req_valid[1] && eligible[1] && !last_grant_q);
    ready[1] = !RESET && eligible[1] && !(req_valid[0] && eligible[0] && last_grant_q);
    grant    = req_valid & ready;
    push     = {stage_valid_q & stage_tag_q, stage_valid_q & ~stage_tag_q};
  end

  // Winner mux; grants are mutually exclusive so grant[1] selects
  assign win_in1 = grant[1] ? REQ1_IN1 : REQ0_IN1;
  assign win_in2 = grant[1] ? REQ1_IN2 : REQ0_IN2;
  assign win_op  = grant[1] ? REQ1_OP  : REQ0_OP;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q[0]      <= 2'd0;
      cnt_q[1]      <= 2'd0;
      last_grant_q  <= 1'b1;
      stage_valid_q <= 1'b0;
      stage_tag_q   <= 1'b0;
      alu_in1_q     <= '0;
      alu_in2_q     <= '0;
      alu_op_q      <= ALU_NOP;
      fifo_rd_q     <= 2'b00;
      fifo_wr_q     <= 2'b00;
      fifo_cnt_q[0] <= 2'd0;
      fifo_cnt_q[1] <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]      <= cnt_q[i] + {1'b0, grant[i]} - {1'b0, pop[i]};
        fifo_cnt_q[i] <= fifo_cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
        if (push[i]) fifo_wr_q[i] <= ~fifo_wr_q[i];
        if (pop[i])  fifo_rd_q[i] <= ~fifo_rd_q[i];
      end
      if (|grant) begin
        last_grant_q  <= grant[1];
        stage_valid_q <= 1'b1;
        stage_tag_q   <= grant[1];
        alu_in1_q     <= win_in1;
        alu_in2_q     <= win_in2;
        alu_op_q      <= win_op;
      end else begin
        // Operands hold to avoid needless toggling into the ALU
        stage_valid_q <= 1'b0;
        alu_op_q      <= ALU_NOP;
      end
    end
  end

  // Storage needs no reset; validity is tracked by fifo_cnt_q
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!RESET && push[i]) begin
        fifo_mem_q[i][fifo_wr_q[i]] <= {ALU_OUT, BRANCH_TAKEN};
      end
    end
  end

  assign head0 = fifo_mem_q[0][fifo_rd_q[0]];
  assign head1 = fifo_mem_q[1][fifo_rd_q[1]];

  assign REQ0_READY      = ready[0];
  assign REQ1_READY      = ready[1];
  assign ALU_IN1         = alu_in1_q;
  assign ALU_IN2         = alu_in2_q;
  assign ALU_INSTRUCTION = alu_op_q;
  assign RSP0_VALID      = rsp_valid[0];
  assign RSP1_VALID      = rsp_valid[1];
  assign RSP0_DATA       = rsp_valid[0] ? head0[DATA_WIDTH:1] : '0;
  assign RSP0_BRANCH     = rsp_valid[0] & head0[0];
  assign RSP1_DATA       = rsp_valid[1] ? head1[DATA_WIDTH:1] : '0;
  assign RSP1_BRANCH     = rsp_valid[1] & head1[0];
  assign BUSY            = !RESET && ((cnt_q[0] != 2'd0) || (cnt_q[1] != 2'd0));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random
// traffic, scored against a queue-based model of the sharing rules.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 5;
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_BEQ = 5'b10000;
  localparam logic [4:0] OP_BNE = 5'b10001;
  localparam logic [4:0] OP_UND = 5'b11111;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ0_VALID, REQ1_VALID;
  logic          REQ0_READY, REQ1_READY;
  logic [DW-1:0] REQ0_IN1, REQ0_IN2, REQ1_IN1, REQ1_IN2;
  logic [OW-1:0] REQ0_OP, REQ1_OP;
  logic [DW-1:0] ALU_IN1, ALU_IN2, ALU_OUT;
  logic [OW-1:0] ALU_INSTRUCTION;
  logic          BRANCH_TAKEN;
  logic          RSP0_VALID, RSP1_VALID, RSP0_READY, RSP1_READY;
  logic [DW-1:0] RSP0_DATA, RSP1_DATA;
  logic          RSP0_BRANCH, RSP1_BRANCH;
  logic          BUSY;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .ALU_NOP(OP_NOP)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_IN1(REQ0_IN1), .REQ0_IN2(REQ0_IN2), .REQ0_OP(REQ0_OP),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_IN1(REQ1_IN1), .REQ1_IN2(REQ1_IN2), .REQ1_OP(REQ1_OP),
    .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2), .ALU_INSTRUCTION(ALU_INSTRUCTION),
    .ALU_OUT(ALU_OUT), .BRANCH_TAKEN(BRANCH_TAKEN),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY),
    .RSP0_DATA(RSP0_DATA), .RSP0_BRANCH(RSP0_BRANCH),
    .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
    .RSP1_DATA(RSP1_DATA), .RSP1_BRANCH(RSP1_BRANCH),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural ALU: {result, branch}
  function automatic logic [DW:0] alu_fn(input logic [4:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    case (op)
      OP_ADD:  return {a + b, 1'b0};
      OP_SUB:  return {a - b, 1'b0};
      OP_BEQ:  return {{DW{1'b0}}, a == b};
      OP_BNE:  return {{DW{1'b0}}, a != b};
      default: return '0;
    endcase
  endfunction

  assign {ALU_OUT, BRANCH_TAKEN} = alu_fn(ALU_INSTRUCTION, ALU_IN1, ALU_IN2);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: one queue per requester of expected responses, each with the
  // first cycle in which it may appear at the FIFO head.
  typedef struct {
    logic [DW-1:0] data;
    logic          br;
    int            vis;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic          last_model = 1'b1;
  logic [4:0]    exp_op = OP_NOP;
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;
  logic          exp_load = 1'b0;
  logic          seen_reset = 1'b0;

  // Monitor samples on the falling edge; a handshake seen here completes on
  // the next rising edge.
  always @(negedge CLK) begin
    logic ev0, ev1, p0, p1, e0, e1, r0, r1, g0, g1;
    exp_t ent;
    if (RESET) begin
      check("reset_req0_ready", REQ0_READY, 0);
      check("reset_req1_ready", REQ1_READY, 0);
      check("reset_rsp0_valid", RSP0_VALID, 0);
      check("reset_rsp1_valid", RSP1_VALID, 0);
      check("reset_busy", BUSY, 0);
      q0.delete();
      q1.delete();
      last_model = 1'b1;
      exp_op     = OP_NOP;
      exp_a      = '0;
      exp_b      = '0;
      exp_load   = 1'b1;
      seen_reset = 1'b1;
    end else if (seen_reset) begin
      check("alu_instruction", ALU_INSTRUCTION, exp_op);
      if (exp_load) begin
        check("alu_in1", ALU_IN1, exp_a);
        check("alu_in2", ALU_IN2, exp_b);
      end
      ev0 = (q0.size() > 0) && (q0[0].vis <= cyc);
      ev1 = (q1.size() > 0) && (q1[0].vis <= cyc);
      check("rsp0_valid", RSP0_VALID, ev0);
      check("rsp1_valid", RSP1_VALID, ev1);
      if (ev0 && RSP0_VALID) begin
        check("rsp0_data", RSP0_DATA, q0[0].data);
        check("rsp0_branch", RSP0_BRANCH, q0[0].br);
      end
      if (ev1 && RSP1_VALID) begin
        check("rsp1_data", RSP1_DATA, q1[0].data);
        check("rsp1_branch", RSP1_BRANCH, q1[0].br);
      end
      p0 = ev0 && RSP0_READY;
      p1 = ev1 && RSP1_READY;
      e0 = (q0.size() - int'(p0)) < 2;
      e1 = (q1.size() - int'(p1)) < 2;
      r0 = e0 && !(REQ1_VALID && e1 && !last_model);
      r1 = e1 && !(REQ0_VALID && e0 && last_model);
      check("req0_ready", REQ0_READY, r0);
      check("req1_ready", REQ1_READY, r1);
      check("busy", BUSY, (q0.size() + q1.size()) != 0);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      g0 = REQ0_VALID && r0;
      g1 = REQ1_VALID && r1;
      exp_op   = OP_NOP;
      exp_load = 1'b0;
      if (g0) begin
        {ent.data, ent.br} = alu_fn(REQ0_OP, REQ0_IN1, REQ0_IN2);
        ent.vis = cyc + 2;
        q0.push_back(ent);
        last_model = 1'b0;
        exp_op = REQ0_OP; exp_a = REQ0_IN1; exp_b = REQ0_IN2; exp_load = 1'b1;
      end
      if (g1) begin
        {ent.data, ent.br} = alu_fn(REQ1_OP, REQ1_IN1, REQ1_IN2);
        ent.vis = cyc + 2;
        q1.push_back(ent);
        last_model = 1'b1;
        exp_op = REQ1_OP; exp_a = REQ1_IN1; exp_b = REQ1_IN2; exp_load = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [4:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return OP_ADD;
      1:       return OP_SUB;
      2:       return OP_BEQ;
      3:       return OP_BNE;
      4:       return OP_NOP;
      default: return OP_UND;
    endcase
  endfunction

  task automatic rand_req0();
    REQ0_OP  = rand_op();
    REQ0_IN1 = $urandom;
    REQ0_IN2 = ($urandom_range(0, 3) == 0) ? REQ0_IN1 : $urandom;
  endtask

  task automatic rand_req1();
    REQ1_OP  = rand_op();
    REQ1_IN1 = $urandom;
    REQ1_IN2 = ($urandom_range(0, 3) == 0) ? REQ1_IN1 : $urandom;
  endtask

  initial begin
    REQ0_VALID = 0; REQ1_VALID = 0;
    REQ0_OP = OP_NOP; REQ1_OP = OP_NOP;
    REQ0_IN1 = 0; REQ0_IN2 = 0; REQ1_IN1 = 0; REQ1_IN2 = 0;
    RSP0_READY = 1; RSP1_READY = 1;
    RESET = 1;
    repeat (3) step();
    RESET = 0;

    // Single ADD 5+7
    REQ0_VALID = 1; REQ0_OP = OP_ADD; REQ0_IN1 = 5; REQ0_IN2 = 7;
    step();
    REQ0_VALID = 0;
    repeat (4) step();

    // Continuous tie, consumers ready
    REQ0_VALID = 1; REQ1_VALID = 1;
    for (int i = 0; i < 8; i++) begin
      rand_req0(); rand_req1();
      step();
    end
    REQ0_VALID = 0; REQ1_VALID = 0;
    repeat (3) step();

    // Backpressure on requester 0
    RSP0_READY = 0;
    REQ0_VALID = 1; REQ0_OP = OP_SUB; REQ1_VALID = 1;
    for (int i = 0; i < 6; i++) begin
      REQ0_IN1 = $urandom; REQ0_IN2 = $urandom; rand_req1();
      step();
    end
    RSP0_READY = 1;
    for (int i = 0; i < 6; i++) begin
      REQ0_IN1 = $urandom; REQ0_IN2 = $urandom; rand_req1();
      step();
    end
    REQ0_VALID = 0; REQ1_VALID = 0;
    repeat (4) step();

    // BEQ then BNE with equal operands
    REQ1_VALID = 1; REQ1_OP = OP_BEQ; REQ1_IN1 = 3; REQ1_IN2 = 3;
    step();
    REQ1_VALID = 0;
    step();
    REQ1_VALID = 1; REQ1_OP = OP_BNE;
    step();
    REQ1_VALID = 0;
    repeat (3) step();

    // Reset in the cycle after a grant: response must vanish
    REQ0_VALID = 1; REQ0_OP = OP_ADD; REQ0_IN1 = 9; REQ0_IN2 = 1;
    step();
    REQ0_VALID = 0;
    RESET = 1;
    step();
    RESET = 0;
    REQ0_VALID = 1; REQ1_VALID = 1; rand_req0(); rand_req1();
    repeat (2) step();
    REQ0_VALID = 0; REQ1_VALID = 0;
    repeat (3) step();

    // Back-to-back issues from requester 0
    REQ0_VALID = 1;
    for (int i = 0; i < 6; i++) begin
      REQ0_OP = OP_ADD; REQ0_IN1 = $urandom; REQ0_IN2 = $urandom;
      step();
    end
    REQ0_VALID = 0;
    repeat (4) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      REQ0_VALID = ($urandom_range(0, 3) != 0);
      REQ1_VALID = ($urandom_range(0, 3) != 0);
      RSP0_READY = ($urandom_range(0, 2) != 0);
      RSP1_READY = ($urandom_range(0, 2) != 0);
      rand_req0(); rand_req1();
      RESET = ($urandom_range(0, 499) == 0);
      step();
    end
    RESET = 0;

    // Drain with a bounded wait
    REQ0_VALID = 0; REQ1_VALID = 0; RSP0_READY = 1; RSP1_READY = 1;
    for (int i = 0; i < 20; i++) begin
      if (q0.size() + q1.size() == 0) break;
      step();
    end
    step();
    check("drain_outstanding", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational execute-stage ALU between two requesters: requester 0 is the integer pipe and requester 1 is the branch/address unit. Each requester has a valid/ready issue port and a valid/ready response port. The block arbitrates round-robin, registers the granted operation into the ALU input register, and captures the ALU result one cycle later into a 2-entry response FIFO per requester. It sits in the execute stage, directly in front of the ALU.

## Interface
Parameters:
- DATA_WIDTH, 32: operand and result width.
- OP_WIDTH, 5: ALU instruction code width.
- ALU_NOP, 5'b00000: code driven to the ALU when idle.

Ports:
- CLK  input  1  Single clock; all state updates on the rising edge.
- RESET  input  1  Synchronous, active-high reset.
- REQ0_VALID / REQ1_VALID  input  1  Issue request present.
- REQ0_READY / REQ1_READY  output  1  Issue accepted this cycle when VALID is also high.
- REQ0_IN1, REQ0_IN2 / REQ1_IN1, REQ1_IN2  input  DATA_WIDTH  Operands.
- REQ0_OP / REQ1_OP  input  OP_WIDTH  ALU instruction code, passed through unmodified.
- ALU_IN1, ALU_IN2  output  DATA_WIDTH  Registered operands to the ALU.
- ALU_INSTRUCTION  output  OP_WIDTH  Registered op to the ALU.
- ALU_OUT  input  DATA_WIDTH  Combinational ALU result.
- BRANCH_TAKEN  input  1  Combinational ALU branch flag.
- RSP0_VALID / RSP1_VALID  output  1  Response FIFO non-empty.
- RSP0_READY / RSP1_READY  input  1  Consumer pops the head when VALID is also high.
- RSP0_DATA / RSP1_DATA  output  DATA_WIDTH  Head-entry result.
- RSP0_BRANCH / RSP1_BRANCH  output  1  Head-entry branch flag.
- BUSY  output  1  High when any operation is in flight or any FIFO is non-empty.

## Operation
**Issue stage**
- Per-requester outstanding counter cnt_x, range 0..2, counts in-flight plus buffered operations.
- pop_x = RSPx_VALID & RSPx_READY.
- eligible_x = (cnt_x - pop_x) < 2.
- Round-robin pointer last_grant (1 bit) holds the most recently granted requester. Reset value is 1, so requester 0 wins the first tie.
- REQ0_READY = eligible_0 & !(REQ1_VALID & eligible_1 & last_grant==0).
- REQ1_READY = eligible_1 & !(REQ0_VALID & eligible_0 & last_grant==1).
- READY never depends on the port's own VALID.
- At most one grant per cycle. grant_x = REQx_VALID & REQx_READY. last_grant updates only on a grant.

**ALU stage register**
- On a grant: load ALU_IN1, ALU_IN2 and ALU_INSTRUCTION from the winner, set stage_valid=1 and stage_tag=winner.
- With no grant: ALU_INSTRUCTION=ALU_NOP, operands hold their previous values, stage_valid=0.

**Response stage**
- When stage_valid=1, push {ALU_OUT, BRANCH_TAKEN} into FIFO[stage_tag] at the end of the cycle.
- Each FIFO has 2 entries, is in-order, and supports a simultaneous push and pop.
- cnt_x next value = cnt_x + grant_x - pop_x.
- Occupancy can never exceed 2, so overflow is impossible by construction.
- A push to an empty FIFO appears at the head in the following cycle. There is no bypass.
- Op codes are not checked. A NOP or an undefined code still produces a response carrying whatever the ALU returns (0).

**Reset**
- Clears cnt_x, both FIFOs, stage_valid and the ALU input register (ALU_INSTRUCTION=ALU_NOP), and sets last_grant=1.
- An in-flight operation is discarded with no response.
- All outputs read 0 during reset and in the cycle after it: READY=0 while RESET is high, RSP_VALID=0, BUSY=0.

## Timing
- Issue accepted on edge t. ALU sees the operands during cycle t+1. Result is pushed on edge t+2. RSPx_VALID is first high in cycle t+2.
- Throughput is one issue per cycle total.
- A single requester with its consumer always ready sustains one issue per cycle: cnt=2 with a pop gives eligible.
- With RSPx_READY held low, requester x can have at most 2 accepted operations. Its REQx_READY returns in the same cycle as the first pop.
- Simultaneous push and pop on a FIFO with one entry: the entry count is unchanged and the head advances.
- Responses for each requester arrive in issue order. There is no ordering guarantee between requesters.

## Test plan
- ADD: REQ0 op=5'b00001, IN1=5, IN2=7, all else idle → REQ0_READY=1. ALU_INSTRUCTION=1 in the next cycle. RSP0_VALID=1 with RSP0_DATA=12 and RSP0_BRANCH=0 two cycles after acceptance.
- Tie after reset: both requesters valid continuously, consumers ready → grants alternate 0,1,0,1. One ALU op per cycle. Each RSP stream is in order.
- Backpressure: RSP0_READY=0 and REQ0 issues 3 SUB ops → the first 2 are accepted, REQ0_READY stays 0 for the third, and REQ1 keeps being granted. Raising RSP0_READY pops 2 responses and the third is accepted in the first pop cycle.
- BEQ: REQ1 op=5'b10000, IN1=IN2=3 → RSP1_BRANCH=1, RSP1_DATA=0. Then BNE with 3,3 → RSP1_BRANCH=0.
- Reset mid-operation: assert RESET in the cycle after a grant → no response ever appears. After RESET deasserts: BUSY=0, ALU_INSTRUCTION=0, and requester 0 wins the next tie.
- Full throughput with one requester: REQ0 issues 6 back-to-back ops with RSP0_READY=1 → REQ0_READY stays 1 throughout and 6 responses arrive on consecutive cycles.
